// File: rtl/alu_seq.sv
// Clocked ALU with Start/Busy/Done handshake: single-cycle logic/compare/shift ops,
// iterative shift-add multiplier and, when ALU_DIV_EN is defined, a restoring divider.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       FS,
    input  logic [SHW-1:0]   SH,
    input  logic [WIDTH-1:0] OprdA,
    input  logic [WIDTH-1:0] OprdB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] FOut,
    output logic [WIDTH-1:0] FOutHi,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             D
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_NOTA = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
        OP_GT   = 4'h8, OP_LT  = 4'h9, OP_EQ  = 4'hA, OP_NE   = 4'hB,
        OP_NOR  = 4'hC, OP_MUL = 4'hD, OP_DIV = 4'hE, OP_PASS = 4'hF
    } op_e;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e           state_q;
    op_e              fs_q;
    logic [SHW-1:0]   sh_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    cnt_q;
    logic             pend_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] fout_q, fouthi_q;
    logic             z_q, c_q, v_q, n_q;

    logic             is_multi;
    logic [WIDTH:0]   sum_w, dif_w;
    logic [WIDTH-1:0] res_d;
    logic             c_d, v_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi_d, step_lo_d;
    logic [WIDTH-1:0] fin_lo_d, fin_hi_d;
    logic             fin_z_d, fin_c_d, fin_v_d, fin_n_d;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_shf, div_try;
`endif

`ifdef ALU_DIV_EN
    assign is_multi = (op_e'(FS) == OP_MUL) || (op_e'(FS) == OP_DIV);
`else
    assign is_multi = (op_e'(FS) == OP_MUL);
`endif

    // Single-cycle result from the operands latched on the previous accept.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum_w = {1'b0, a_q} + {1'b0, b_q};
        dif_w = {1'b0, a_q} - {1'b0, b_q};
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (fs_q)
            OP_ADD: begin
                res_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
                v_d   = ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_d[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = dif_w[WIDTH-1:0];
                c_d   = dif_w[WIDTH];
                v_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_d[WIDTH-1]);
            end
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_XOR:  res_d = a_q ^ b_q;
            OP_NOTA: res_d = ~a_q;
            OP_SHL:  res_d = a_q << sh_q;
            OP_SHR:  res_d = a_q >> sh_q;
            OP_GT:   res_d = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
            OP_LT:   res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            OP_NE:   res_d = {{(WIDTH-1){1'b0}}, (a_q != b_q)};
            OP_NOR:  res_d = ~(a_q | b_q);
            default: res_d = a_q;
        endcase
    end

    // One iteration step: MUL shifts {hi,lo} right after a conditional add,
    // DIV shifts left and keeps the trial subtraction when it does not borrow.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, a_q});
        step_hi_d = mul_sum[WIDTH:1];
        step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_shf = {hi_q, lo_q[WIDTH-1]};
        div_try = div_shf - {1'b0, b_q};
        if (fs_q == OP_DIV) begin
            if (!div_try[WIDTH]) begin
                step_hi_d = div_try[WIDTH-1:0];
                step_lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_d = div_shf[WIDTH-1:0];
                step_lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        fin_lo_d = lo_q;
        fin_hi_d = hi_q;
        fin_z_d  = ({hi_q, lo_q} == '0);
        fin_n_d  = hi_q[WIDTH-1];
        fin_c_d  = (hi_q != '0);
        fin_v_d  = 1'b0;
`ifdef ALU_DIV_EN
        if (fs_q == OP_DIV) begin
            if (b_q == '0) begin
                fin_lo_d = '1;
                fin_hi_d = a_q;
                fin_v_d  = 1'b1;
            end
            fin_z_d = (fin_lo_d == '0);
            fin_n_d = fin_lo_d[WIDTH-1];
            fin_c_d = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fs_q     <= OP_ADD;
            sh_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fout_q   <= '0;
            fouthi_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A pending single-cycle op retires in the same edge a new one is accepted.
                    if (pend_q) begin
                        fout_q   <= res_d;
                        fouthi_q <= '0;
                        z_q      <= (res_d == '0);
                        c_q      <= c_d;
                        v_q      <= v_d;
                        n_q      <= res_d[WIDTH-1];
                        done_q   <= 1'b1;
                    end
                    pend_q <= 1'b0;
                    if (Start) begin
                        fs_q <= op_e'(FS);
                        sh_q <= SH;
                        a_q  <= OprdA;
                        b_q  <= OprdB;
                        if (is_multi) begin
                            state_q <= ST_RUN;
                            cnt_q   <= CW'(WIDTH);
                            hi_q    <= '0;
                            lo_q    <= (op_e'(FS) == OP_MUL) ? OprdB : OprdA;
                        end else begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        hi_q   <= step_hi_d;
                        lo_q   <= step_lo_d;
                        cnt_q  <= cnt_q - 1'b1;
                        busy_q <= 1'b1;
                    end else begin
                        fout_q   <= fin_lo_d;
                        fouthi_q <= fin_hi_d;
                        z_q      <= fin_z_d;
                        c_q      <= fin_c_d;
                        v_q      <= fin_v_d;
                        n_q      <= fin_n_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign FOut   = fout_q;
    assign FOutHi = fouthi_q;
    assign Z      = z_q;
    assign C      = c_q;
    assign V      = v_q;
    assign N      = n_q;
    assign D      = v_q ^ n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops plus
// hand-written MUL/DIV, reset-abort and back-to-back sequences.
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_AND = 4'h2, F_OR  = 4'h3,
                           F_XOR = 4'h4, F_NOT = 4'h5, F_SHL = 4'h6, F_SHR = 4'h7,
                           F_GT  = 4'h8, F_LT  = 4'h9, F_EQ  = 4'hA, F_NE  = 4'hB,
                           F_NOR = 4'hC, F_MUL = 4'hD, F_DIV = 4'hE, F_PAS = 4'hF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   fs;
    logic [2:0]   sh;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] fout, fout_hi;
    logic         z, c, v, n, d;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (start),
        .FS    (fs),
        .SH    (sh),
        .OprdA (a),
        .OprdB (b),
        .Busy  (busy),
        .Done  (done),
        .FOut  (fout),
        .FOutHi(fout_hi),
        .Z     (z),
        .C     (c),
        .V     (v),
        .N     (n),
        .D     (d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   fs;
        logic [2:0]   sh;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic [W-1:0] h;
        logic [4:0]   flg;   // {Z,C,V,N,D}
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [2:0] s,
                         input logic [W-1:0] oa, input logic [W-1:0] ob);
        fs    = f;
        sh    = s;
        a     = oa;
        b     = ob;
        start = 1'b1;
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ef,
                                input logic [W-1:0] eh, input logic [4:0] eflg);
        check({name, " fout"}, 64'(fout), 64'(ef));
        check({name, " fouthi"}, 64'(fout_hi), 64'(eh));
        check({name, " flags"}, 64'({z, c, v, n, d}), 64'(eflg));
    endtask

    // Multi-cycle op: noise on the inputs while running must not matter.
    task automatic run_multi(input string name, input logic [3:0] f,
                             input logic [W-1:0] oa, input logic [W-1:0] ob,
                             input logic [W-1:0] ef, input logic [W-1:0] eh,
                             input logic [4:0] eflg);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        int extra    = 0;
        drive(f, 3'd0, oa, ob);
        tick();
        drive(F_ADD, 3'd1, 8'h01, 8'h01);
        for (int i = 1; i <= W + 1; i++) begin
            if (i == W + 1) start = 1'b0;
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
        end
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(W));
        check({name, " done edge"}, 64'(done_at), 64'(W + 1));
        check({name, " done count"}, 64'(done_cnt), 64'd1);
        check({name, " busy at done"}, 64'(busy), 64'd0);
        check_result(name, ef, eh, eflg);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) extra++;
        end
        check({name, " no extra done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{F_ADD, 3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b11000};
        vecs[1]  = '{F_SUB, 3'd0, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00101};
        vecs[2]  = '{F_SUB, 3'd0, 8'h01, 8'h02, 8'hFF, 8'h00, 5'b01011};
        vecs[3]  = '{F_AND, 3'd0, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000};
        vecs[4]  = '{F_OR,  3'd0, 8'h0F, 8'h80, 8'h8F, 8'h00, 5'b00011};
        vecs[5]  = '{F_XOR, 3'd0, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b10000};
        vecs[6]  = '{F_NOT, 3'd0, 8'h0F, 8'h55, 8'hF0, 8'h00, 5'b00011};
        vecs[7]  = '{F_SHL, 3'd1, 8'h81, 8'h00, 8'h02, 8'h00, 5'b00000};
        vecs[8]  = '{F_SHR, 3'd3, 8'h81, 8'h00, 8'h10, 8'h00, 5'b00000};
        vecs[9]  = '{F_GT,  3'd0, 8'h80, 8'h7F, 8'h01, 8'h00, 5'b00000};
        vecs[10] = '{F_LT,  3'd0, 8'h80, 8'h7F, 8'h00, 8'h00, 5'b10000};
        vecs[11] = '{F_EQ,  3'd0, 8'h5A, 8'h5A, 8'h01, 8'h00, 5'b00000};
        vecs[12] = '{F_NE,  3'd0, 8'h5A, 8'h5A, 8'h00, 8'h00, 5'b10000};
        vecs[13] = '{F_NOR, 3'd0, 8'h0F, 8'hF0, 8'h00, 8'h00, 5'b10000};
        vecs[14] = '{F_PAS, 3'd0, 8'hC3, 8'h11, 8'hC3, 8'h00, 5'b00011};
        vecs[15] = '{F_ADD, 3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b00110};

        rst_n = 1'b0;
        drive(F_ADD, 3'd0, 8'h00, 8'h00);
        start = 1'b0;
        tick();
        tick();
        check("reset fout", 64'(fout), 64'd0);
        check("reset fouthi", 64'(fout_hi), 64'd0);
        check("reset busy/done", 64'({busy, done}), 64'd0);
        check("reset flags", 64'({z, c, v, n, d}), 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].fs, vecs[i].sh, vecs[i].a, vecs[i].b);
            tick();
            start = 1'b0;
            check($sformatf("v%0d done before k+1", i), 64'(done), 64'd0);
            tick();
            check($sformatf("v%0d done/busy", i), 64'({done, busy}), 64'b10);
            check_result($sformatf("v%0d", i), vecs[i].f, vecs[i].h, vecs[i].flg);
            tick();
            check($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
        end

        run_multi("mul ff*ff", F_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01011);

`ifdef ALU_DIV_EN
        run_multi("div 100/7", F_DIV, 8'd100, 8'd7, 8'd14, 8'd2, 5'b00000);
        run_multi("div 55/0", F_DIV, 8'h55, 8'h00, 8'hFF, 8'h55, 5'b00110);
`else
        drive(F_DIV, 3'd0, 8'd100, 8'd7);
        tick();
        start = 1'b0;
        tick();
        check("nodiv done/busy", 64'({done, busy}), 64'b10);
        check_result("nodiv 100/7", 8'd100, 8'h00, 5'b00000);
        tick();
`endif

        run_multi("mul 12*34", F_MUL, 8'h12, 8'h34, 8'hA8, 8'h03, 5'b01000);

        // Reset during the fourth busy cycle of a MUL.
        drive(F_MUL, 3'd0, 8'hFF, 8'hFF);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mul busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        check("abort fout", 64'(fout), 64'd0);
        check("abort fouthi", 64'(fout_hi), 64'd0);
        check("abort busy/done", 64'({busy, done}), 64'd0);
        check("abort flags", 64'({z, c, v, n, d}), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done || busy) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);
        drive(F_ADD, 3'd0, 8'd3, 8'd4);
        tick();
        start = 1'b0;
        tick();
        check("post-reset add done", 64'(done), 64'd1);
        check_result("post-reset add", 8'd7, 8'h00, 5'b00000);
        tick();

        // Back-to-back single-cycle ops.
        drive(F_ADD, 3'd0, 8'd1, 8'd2);
        tick();
        drive(F_ADD, 3'd0, 8'd10, 8'd20);
        tick();
        check("b2b first done", 64'(done), 64'd1);
        check("b2b first fout", 64'(fout), 64'd3);
        drive(F_SUB, 3'd0, 8'd5, 8'd5);
        tick();
        start = 1'b0;
        check("b2b second done", 64'(done), 64'd1);
        check("b2b second fout", 64'(fout), 64'h1E);
        tick();
        check("b2b third done", 64'(done), 64'd1);
        check_result("b2b third", 8'h00, 8'h00, 5'b10000);
        tick();
        check("b2b idle", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the datapath ALU. It latches operands on a start handshake and produces registered results and flags. Logic, compare and shift ops take a single cycle; an iterative shift-add multiplier and an optional restoring divider take WIDTH cycles. It sits between the register file and the write-back mux, and the control FSM drives it through a Start/Busy/Done handshake.

## Interface
- WIDTH, 8: operand and result width (≥4)
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridable)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous and active-low
- Start  in  1  request; accepted only while Busy=0
- FS  in  4  function select, sampled on accept
- SH  in  SHW  shift amount, sampled on accept
- OprdA, OprdB  in  WIDTH  operands, sampled on accept
- Busy  out  1  high while a multi-cycle op is running
- Done  out  1  one-cycle pulse; outputs are valid from this cycle on
- FOut  out  WIDTH  result (low product / quotient)
- FOutHi  out  WIDTH  high product / remainder; 0 for all other ops
- Z, C, V, N, D  out  1  zero, carry/borrow, overflow, negative, signed-less (V^N)

## Operation
- FS encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SHL A by SH, 7 SHR A by SH (logical)
  - 8 A>B, 9 A<B, A A==B, B A!=B (compares are unsigned; result is 0 or 1, zero-extended)
  - C NOR, D MUL (unsigned), E DIV (unsigned), F pass A
- States: IDLE, RUN.
  - In IDLE, Start=1 latches FS, SH, OprdA and OprdB.
  - Single-cycle op: stay in IDLE, register the result, pulse Done.
  - MUL/DIV: go to RUN, load the iteration counter with WIDTH.
  - RUN: one shift-add (MUL) or one restore step (DIV) per cycle; counter decrements; at zero, register the result, pulse Done, return to IDLE.
- Flags, computed on the registered result:
  - Z = (FOut==0), or ({FOutHi,FOut}==0) for MUL. N = FOut[WIDTH-1], or FOutHi[WIDTH-1] for MUL.
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow.
  - SUB: C = borrow (A<B unsigned); V = (A^B)&(A^R) MSB.
  - MUL: C = (FOutHi != 0); V = 0.
  - DIV: C = 0; V = 1 only on divide-by-zero.
  - All other ops: C = 0, V = 0.
  - D = V^N always.
- Divide-by-zero: FOut = all ones, FOutHi = OprdA, V = 1. Still takes the full WIDTH cycles.
- Start while Busy=1 is ignored; no queueing. Outputs and flags hold between Done pulses.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, Busy=0, Done=0, FOut=0, FOutHi=0, all flags 0. Reset aborts any RUN with no Done.
- Single-cycle op, Start accepted at edge k: results and Done=1 at edge k+1, Busy stays 0.
- MUL/DIV, Start accepted at edge k: Busy=1 over edges k+1..k+WIDTH; results and Done=1 at edge k+WIDTH+1, Busy=0 at that edge.
- Back-to-back: Start asserted in the Done cycle is accepted. Sustained throughput is 1 op/cycle for single-cycle ops.
- Done is never high for two consecutive cycles from the same op.
- Input changes after accept have no effect on the op in flight.

## Configuration
- ALU_DIV_EN defined: divider datapath compiled in; FS=E behaves as above.
- ALU_DIV_EN undefined: no divider logic. FS=E is treated as pass A, single-cycle: FOut=A, FOutHi=0, C=V=0.

## Test plan
- WIDTH=8, ADD A=0xFF, B=0x01: Done at k+1, FOut=0x00, Z=1, C=1, V=0, N=0.
- SUB A=0x80, B=0x01: FOut=0x7F, V=1, N=0, D=1, C=0. Then SUB A=0x01, B=0x02: FOut=0xFF, C=1, N=1.
- MUL A=0xFF, B=0xFF: Busy high for exactly 8 cycles, Done at k+9, {FOutHi,FOut}=0xFE01, C=1. Start pulses during Busy are ignored, with no extra Done.
- DIV 100/7 (ALU_DIV_EN): FOut=14, FOutHi=2, V=0. DIV 0x55/0: FOut=0xFF, FOutHi=0x55, V=1. Without the macro, DIV 100/7: FOut=100 at k+1.
- rst_n low during MUL cycle 4: next edge all outputs 0, state IDLE, no Done. A fresh ADD 3+4 then gives FOut=7 at k+1.
- SHL A=0x81, SH=1: FOut=0x02, C=0. GT A=0x80, B=0x7F: FOut=0x01. Back-to-back ADDs on consecutive cycles give Done on consecutive cycles.
